dualportram_clr: RTL

- Parametrised successor to the plain single-clock dual-port RAM.
- Adds per-lane write enables, a read enable with output hold, and a selectable read-during-write mode.
- Adds an optional second output register and a hardware clear of the whole array after reset, with ready/valid status.
- Used as the register-file / scratch RAM primitive for iCE40 EBR and GateMate block RAM targets.

---
 rtl/dualportram_pkg.sv | 27 ++
 rtl/dualportram_lane.sv | 47 ++++
 rtl/dualportram_clr.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dualportram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dualportram_pkg
//  Description : Shared types and helpers for the clearable dual-port RAM.
//  Revision    : 1.0 - initial release
// ============================================================================
package dualportram_pkg;

  // Top-level controller states: sweeping the array, or serving the ports
  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // Value returned when the read and write ports hit the same word
  typedef enum logic [0:0] {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } rdw_mode_t;

  // Width of one independently writable lane
  function automatic int lane_width(input int data_width, input int lanes);
    return data_width / lanes;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dualportram_lane.sv
`default_nettype none
// ============================================================================
//  Module      : dualportram_lane
//  Description : One lane of the RAM array. Synchronous write, asynchronous
//                read path with optional write-first collision bypass. The
//                read register lives in the top level so it can be reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module dualportram_lane
  import dualportram_pkg::*;
#(
  parameter int ADDRBITS = 9,
  parameter int LW       = 8,
  parameter int RDW_MODE = 0
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRBITS-1:0] waddr,
  input  logic [LW-1:0]       wdata,
  input  logic [ADDRBITS-1:0] raddr,
  output logic [LW-1:0]       rdata
);

  localparam int DEPTH = 1 << ADDRBITS;

  // Storage array; never reset, the top level sweeps it instead
  logic [LW-1:0] mem_q [DEPTH];

  // Write port: one word per cycle when this lane is enabled
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  generate
    if (RDW_MODE == int'(WRITE_FIRST)) begin : g_write_first
      // A same-address write in this cycle overrides the stored word
      assign rdata = (we && (waddr == raddr)) ? wdata : mem_q[raddr];
    end else begin : g_read_first
      // Stored word is sampled before the concurrent write lands
      assign rdata = mem_q[raddr];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dualportram_clr.sv
`default_nettype none
// ============================================================================
//  Module      : dualportram_clr
//  Description : Single-clock dual-port RAM with per-lane write enables,
//                read enable with output hold, selectable read-during-write
//                behaviour, optional second output register and a hardware
//                clear sweep after reset with a ready status flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module dualportram_clr
  import dualportram_pkg::*;
#(
  parameter int                   ADDRBITS       = 9,
  parameter int                   DATAWIDTH      = 8,
  parameter int                   LANES          = 1,
  parameter int                   OUTREG         = 0,
  parameter int                   RDW_MODE       = 0,
  parameter int                   CLEAR_ON_RESET = 1,
  parameter logic [DATAWIDTH-1:0] CLEAR_VALUE    = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDRBITS-1:0]  waddr,
  input  logic [DATAWIDTH-1:0] din,
  input  logic [LANES-1:0]     wlane,
  input  logic                 write_en,
  input  logic [ADDRBITS-1:0]  raddr,
  input  logic                 read_en,
  output logic [DATAWIDTH-1:0] dout,
  output logic                 dout_valid,
  output logic                 ready
);

  localparam int                  LW          = lane_width(DATAWIDTH, LANES);
  localparam state_t              RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
  localparam logic [ADDRBITS-1:0] CNT_ONE     = {{(ADDRBITS-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [ADDRBITS-1:0]  cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [DATAWIDTH-1:0] rd1_data_q, rd1_data_d;
  logic                 rd1_valid_q, rd1_valid_d;

  logic [ADDRBITS-1:0]  mem_waddr;
  logic [DATAWIDTH-1:0] mem_wdata;
  logic [LANES-1:0]     mem_we;
  logic [DATAWIDTH-1:0] mem_rdata;

  // Write-port mux: the clear engine owns the array until the sweep ends
  always_comb begin
    mem_waddr = waddr;
    mem_wdata = din;
    mem_we    = write_en ? wlane : '0;
    if (state_q == CLEAR) begin
      mem_waddr = cnt_q;
      mem_wdata = CLEAR_VALUE;
      mem_we    = '1;
    end
  end

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      dualportram_lane #(
        .ADDRBITS (ADDRBITS),
        .LW       (LW),
        .RDW_MODE (RDW_MODE)
      ) u_lane (
        .clk   (clk),
        .we    (mem_we[i]),
        .waddr (mem_waddr),
        .wdata (mem_wdata[i*LW +: LW]),
        .raddr (raddr),
        .rdata (mem_rdata[i*LW +: LW])
      );
    end
  endgenerate

  // Next-state logic: sweep addresses until the last word, then serve ports
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (&cnt_q) begin
          state_d = RUN;
        end
      end
      RUN:     state_d = RUN;
      default: state_d = RESET_STATE;
    endcase
    ready_d = (state_d == RUN);
  end

  // First read stage: load only on an accepted read, otherwise hold data
  always_comb begin
    rd1_valid_d = (state_q == RUN) && read_en;
    rd1_data_d  = rd1_valid_d ? mem_rdata : rd1_data_q;
  end

  // Controller and first read stage registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= RESET_STATE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      rd1_data_q  <= '0;
      rd1_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      rd1_data_q  <= rd1_data_d;
      rd1_valid_q <= rd1_valid_d;
    end
  end

  assign ready = ready_q;

  generate
    if (OUTREG != 0) begin : g_outreg
      logic [DATAWIDTH-1:0] rd2_data_q, rd2_data_d;
      logic                 rd2_valid_q, rd2_valid_d;

      // Second stage follows the first every cycle, loading data only when valid
      always_comb begin
        rd2_valid_d = rd1_valid_q;
        rd2_data_d  = rd1_valid_q ? rd1_data_q : rd2_data_q;
      end

      // Second read stage registers
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          rd2_data_q  <= '0;
          rd2_valid_q <= 1'b0;
        end else begin
          rd2_data_q  <= rd2_data_d;
          rd2_valid_q <= rd2_valid_d;
        end
      end

      assign dout       = rd2_data_q;
      assign dout_valid = rd2_valid_q;
    end else begin : g_no_outreg
      assign dout       = rd1_data_q;
      assign dout_valid = rd1_valid_q;
    end
  endgenerate

endmodule
`default_nettype wire
